// File: rtl/fifo_thresh.sv
`default_nettype none
// ============================================================================
// Module   : fifo_thresh
// Purpose  : Synchronous first-word-fall-through FIFO with occupancy count,
//            programmable almost-full/almost-empty thresholds, sticky
//            overflow/underflow flags and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_thresh #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int PTRWID   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTRWID-1:0] count,
  output logic              overflow,
  output logic              underflow
);

  // Index width into the storage array; the pointer carries one extra wrap bit.
  localparam int IDXW = PTRWID - 1;

  // Thresholds resized to the count width so the comparisons are width-exact.
  localparam logic [PTRWID-1:0] AF_LEVEL = PTRWID'(AF_THRESH);
  localparam logic [PTRWID-1:0] AE_LEVEL = PTRWID'(AE_THRESH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTRWID-1:0] r_wr_ptr;
  logic [PTRWID-1:0] r_rd_ptr;
  logic              r_overflow;
  logic              r_underflow;

  logic [WIDTH-1:0]  w_entries [DEPTH];

  // --------------------------------------------------------------------------
  // Status decode (registered state only, never from push/pop/data_in)
  // --------------------------------------------------------------------------
  logic              w_full;
  logic              w_empty;
  logic [PTRWID-1:0] w_count;

  // Equal pointers mean empty; equal index with differing wrap bit means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[IDXW-1:0] == r_rd_ptr[IDXW-1:0]) &&
                   (r_wr_ptr[PTRWID-1] != r_rd_ptr[PTRWID-1]);

  // Modular difference of the wrap-extended pointers is the occupancy 0..DEPTH.
  assign w_count = r_wr_ptr - r_rd_ptr;

  // --------------------------------------------------------------------------
  // Request qualification
  // --------------------------------------------------------------------------
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_set;
  logic w_unf_set;

  // A push into a full FIFO still succeeds when a pop vacates the head slot.
  // Flush overrides both requests and suppresses any error they would raise.
  assign w_push_ok = push && (!w_full || pop) && !flush;
  assign w_pop_ok  = pop && !w_empty && !flush;
  assign w_ovf_set = push && w_full && !pop && !flush;
  assign w_unf_set = pop && w_empty && !flush;

  // --------------------------------------------------------------------------
  // Pointer registers
  // --------------------------------------------------------------------------
  // Write pointer: cleared by flush, advanced by each accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
    end else if (w_push_ok) begin
      r_wr_ptr <= r_wr_ptr + PTRWID'(1);
    end
  end

  // Read pointer: cleared by flush, advanced by each accepted pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
    end else if (w_pop_ok) begin
      r_rd_ptr <= r_rd_ptr + PTRWID'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags (a new error in the same cycle beats clr_err)
  // --------------------------------------------------------------------------
  // Overflow: set by a dropped push, cleared by clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (clr_err) begin
      r_overflow <= 1'b0;
    end
  end

  // Underflow: set by a dropped pop, cleared by clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow <= 1'b0;
    end else if (w_unf_set) begin
      r_underflow <= 1'b1;
    end else if (clr_err) begin
      r_underflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: one register per entry, each with its own write enable so a
  // dropped push can never disturb stored data. Flush leaves contents intact.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic             w_wr_en;
    logic [WIDTH-1:0] r_data;

    assign w_wr_en = w_push_ok && (r_wr_ptr[IDXW-1:0] == IDXW'(gi));

    // Entry register: loads data_in only when this slot is the write target.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= '0;
      end else if (w_wr_en) begin
        r_data <= data_in;
      end
    end

    assign w_entries[gi] = r_data;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Head entry is presented continuously (first-word fall-through).
  assign data_out     = w_entries[r_rd_ptr[IDXW-1:0]];
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = w_count;
  assign almost_full  = (w_count >= AF_LEVEL);
  assign almost_empty = (w_count <= AE_LEVEL);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_thresh.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_thresh
// Purpose  : Directed self-checking bench for fifo_thresh (DEPTH=8, AF=6,
//            AE=1) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_thresh;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int PTRWID = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [PTRWID-1:0] count;
  logic              overflow;
  logic              underflow;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_thresh #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_THRESH(6),
    .AE_THRESH(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (push),
    .pop         (pop),
    .clr_err     (clr_err),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1 unit after the rising edge with
  // the inputs back at idle.
  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic f, input logic c);
    push = p; pop = q; data_in = d; flush = f; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = 8'h00; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = 8'h00;

    // ---- Reset defaults ----
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    #10;
    rst = 1'b0;

    // ---- First push falls through ----
    step(1, 0, 8'h11, 0, 0);
    chk("p1_dout", data_out, 8'h11);
    chk("p1_count", count, 1);
    chk("p1_empty", empty, 0);
    chk("p1_ae", almost_empty, 1);
    step(0, 1, 8'h00, 0, 0);
    chk("p1_pop_empty", empty, 1);

    // ---- Fill 0x00..0x07, watch thresholds ----
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(i), 0, 0);
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
      chk("fill_full", full, (i + 1 == 8) ? 1 : 0);
      chk("fill_ae", almost_empty, (i + 1 <= 1) ? 1 : 0);
    end

    // ---- Ninth push is dropped ----
    step(1, 0, 8'hAA, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_dout", data_out, 8'h00);

    // ---- Drain in order ----
    for (int i = 0; i < 8; i++) begin
      chk("drain_dout", data_out, i);
      step(0, 1, 8'h00, 0, 0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // ---- clr_err clears overflow ----
    step(0, 0, 8'h00, 0, 1);
    chk("clr_ovf", overflow, 0);

    // ---- Push+pop while full ----
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0, 0);
    chk("pp_full_pre", full, 1);
    chk("pp_head_pre", data_out, 8'h00);
    step(1, 1, 8'h55, 0, 0);
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", data_out, 8'h01);
    for (int i = 1; i < 8; i++) begin
      chk("pp_drain", data_out, i);
      step(0, 1, 8'h00, 0, 0);
    end
    chk("pp_last", data_out, 8'h55);
    step(0, 1, 8'h00, 0, 0);
    chk("pp_empty", empty, 1);

    // ---- Underflow and clr_err priority ----
    step(0, 1, 8'h00, 0, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 0);
    step(0, 0, 8'h00, 0, 1);
    chk("unf_clr", underflow, 0);
    step(0, 1, 8'h00, 0, 1);
    chk("unf_set_wins", underflow, 1);
    // Push with pop on empty: push taken, pop dropped.
    step(0, 0, 8'h00, 0, 1);
    step(1, 1, 8'h3C, 0, 0);
    chk("pe_count", count, 1);
    chk("pe_dout", data_out, 8'h3C);
    chk("pe_unf", underflow, 1);
    step(0, 1, 8'h00, 0, 1);
    chk("pe_drain", empty, 1);
    chk("pe_clr", underflow, 0);

    // ---- Flush with push ----
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h20 + i), 0, 0);
    chk("fl_pre_count", count, 5);
    step(1, 1, 8'hEE, 1, 0);
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_ovf", overflow, 0);
    chk("fl_unf", underflow, 0);

    // ---- 20 push/pop pairs across pointer wrap ----
    step(1, 0, 8'h80, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 8'(8'h80 + k), 0, 0);
      chk("wrap_dout", data_out, 8'h80 + k);
      chk("wrap_count", count, 1);
    end
    step(0, 1, 8'h00, 0, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_ae", almost_empty, 1);

    // ---- Asynchronous reset mid-cycle ----
    step(0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
    chk("ar_pre_count", count, 4);
    chk("ar_pre_unf", underflow, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_dout", data_out, 8'h00);
    chk("ar_unf", underflow, 0);
    chk("ar_ae", almost_empty, 1);
    #1;
    rst = 1'b0;
    step(1, 0, 8'h77, 0, 0);
    chk("ar_resume_count", count, 1);
    chk("ar_resume_dout", data_out, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_thresh.md
# fifo_thresh

Parametrised synchronous FIFO, successor to the basic pointer-based FIFO. It adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between producer/consumer datapath stages that need early back-pressure and error visibility. Reads are first-word-fall-through: the head entry is always presented on `data_out`.

## Interface
- `WIDTH`, 8, data width in bits (>=1)
- `DEPTH`, 8, number of entries; power of two, >=2
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when count >= AF_THRESH (1..DEPTH)
- `AE_THRESH`, 1, `almost_empty` asserts when count <= AE_THRESH (0..DEPTH-1)
- `PTRWID`, $clog2(DEPTH)+1, pointer width incl. wrap bit (derived, not overridden)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous clear of pointers and count; stored data not cleared
- `push`  in  1  write request
- `pop`  in  1  read request; `data_out` is consumed this cycle
- `clr_err`  in  1  synchronous clear of the sticky error flags
- `data_in`  in  WIDTH  write data
- `data_out`  out  WIDTH  head entry, `entries[rdPtr[PTRWID-2:0]]`
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= AF_THRESH
- `almost_empty`  out  1  count <= AE_THRESH
- `count`  out  PTRWID  occupancy, 0..DEPTH
- `overflow`  out  1  sticky: a push was dropped
- `underflow`  out  1  sticky: a pop was dropped

## Operation
- Pointers `wrPtr` and `rdPtr` are PTRWID-bit registers and wrap modulo 2^PTRWID.
  - Entry index is `ptr[PTRWID-2:0]`.
  - `full`/`empty` are derived from the pointers as in the existing FIFO: equal pointers = empty; equal index bits with differing MSB = full.
  - `count` = `wrPtr - rdPtr` (PTRWID-bit subtraction) and must always agree with `full`/`empty`.
- Accepted push: `push & (!full | pop)`. Write `data_in` to `entries[wrPtr idx]`, increment `wrPtr`.
- Accepted pop: `pop & !empty`. Increment `rdPtr`.
- Push while full with no pop: dropped, no state change except `overflow` <= 1.
- Push and pop while full: both accepted; count stays DEPTH. The write lands in the slot being vacated; the current `data_out` is the value consumed.
- Pop while empty: dropped, `underflow` <= 1. If `push` is also high, the push is still accepted.
- Push and pop while not full and not empty: both accepted, count unchanged.
- `flush`:
  - Next edge: `wrPtr`/`rdPtr` <= 0; `push`/`pop` in the same cycle are ignored and raise no error.
  - Error flags are not affected by `flush`.
- `clr_err`: next edge, `overflow`/`underflow` <= 0. If a new error occurs in the same cycle, set wins.
- Priority per edge: `rst` (async) > `flush` > push/pop.
- Entry registers are written only on an accepted push (one enable per entry), so dropped pushes never corrupt data.

## Timing
- Reset (async, immediate, independent of `clk`):
  - pointers = 0, count = 0, entries = 0, so `data_out` = 0;
  - `empty` = 1, `full` = 0, `almost_full` = 0 (AF_THRESH >= 1), `almost_empty` = 1;
  - `overflow` = `underflow` = 0.
- All outputs are combinational functions of registered state only. They change just after the rising edge and never combinationally from `push`/`pop`/`data_in`.
- Push at edge N into an empty FIFO: `empty` falls and `data_out` = written data after edge N (zero-cycle fall-through latency after the write edge).
- Pop at edge N: `data_out` shows the next entry after edge N.
- `count` and all flags reflect an edge-N operation immediately after edge N.
- Reset asserted mid-burst: state clears immediately. Operations resume on the first edge after `rst` deasserts.
- Wrap: after 2^PTRWID total pushes and equal pops, pointers return to 0 with no flag glitch.

## Test plan
- Reset, then check defaults: `empty`=1, `almost_empty`=1, `count`=0, `data_out`=0, errors 0. Push 0x11 -> next cycle `data_out`=0x11, `count`=1, `empty`=0, `almost_empty`=1.
- DEPTH=8, AF=6: push 0x00..0x07.
  - `almost_full` rises when count hits 6; `full` rises at 8.
  - A 9th push (0xAA) -> `overflow`=1, `count`=8, `data_out`=0x00.
  - Pop all 8 -> outputs 0x00..0x07 in order, `empty`=1.
- Pop on empty -> `underflow`=1, `count` stays 0. Pulse `clr_err` -> `underflow`=0 next cycle. `clr_err` with a simultaneous pop on empty -> `underflow` stays 1.
- Full FIFO, push 0x55 with pop the same cycle -> 0x00 consumed, `count`=8, no `overflow`. 0x55 emerges eighth.
- Fill 5 entries, assert `flush` with `push` -> `count`=0, `empty`=1, no error. Then 20 push/pop pairs across pointer wrap -> data order preserved.
- Assert `rst` asynchronously between edges with count=4 -> all outputs return to reset values before the next edge.
